logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2-operand bitwise logic unit among NUM_REQ requesters.
- The logic unit supports AND, OR, XOR and NAND.
- Each cycle it selects at most one requesting client and evaluates that client's operands.
- The result is captured in a single output register with a valid/ready handshake, tagged with the winner's index.
- It sits between the client blocks and the downstream result consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width in bits.
- ID_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  NUM_REQ  per-requester request; held high until granted.
- op_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- op_b  input  NUM_REQ*WIDTH  operand B, packed the same way.
- op_sel  input  NUM_REQ*2  opcode; requester i occupies bits [i*2 +: 2]. 00 AND, 01 OR, 10 XOR, 11 NAND.
- gnt  output  NUM_REQ  one-hot grant, combinational (same cycle as issue).
- res_valid  output  1  result register holds valid data.
- res_data  output  WIDTH  registered result.
- res_id  output  ID_W  index of the requester that produced res_data.
- res_ready  input  1  consumer accepts the result when high together with res_valid.
- grant_cnt  output  16  saturating count of issued operations.

Behaviour:
- Reset: clk plus rst, with rst asynchronous and active-high. While rst is high:
  - res_valid=0, res_data=0, res_id=0, grant_cnt=0.
  - Priority pointer ptr=0.
  - gnt is forced to 0.
- can_issue = !res_valid || res_ready. The output register is empty, or it is being drained this cycle.
- Winner selection:
  - If can_issue and |req, the winner w is the first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - gnt[w]=1 that cycle. All other gnt bits are 0.
  - If !can_issue or no req, gnt=0.
- On the edge after an issue:
  - res_data = f(op_a[w], op_b[w], op_sel[w]); res_id=w; res_valid=1.
  - ptr = (w+1) mod NUM_REQ. Wrap from NUM_REQ-1 to 0.
  - grant_cnt increments, saturating at 16'hFFFF.
- Latency: one cycle from grant to res_valid.
- Throughput: one result per cycle while res_ready stays high.
- Drain without issue: if res_valid && res_ready and nothing is issued, then res_valid becomes 0 next edge. res_data and res_id hold their values.
- Simultaneous drain and issue: the new result overwrites with no bubble, and res_valid stays 1.
- Backpressure: if res_valid && !res_ready, then:
  - res_data, res_id and res_valid hold.
  - gnt=0 and ptr holds.
- Requester protocol:
  - A requester must keep req, op_a, op_b and op_sel stable until it sees gnt.
  - It may drop req in the cycle after gnt, or keep it high to request again.
- ptr advances only on an issue.
- Fairness: under continuous contention every requester is granted within NUM_REQ issue cycles.
- Reset mid-operation: any pending result is discarded, res_valid=0, and ptr returns to 0.

Decomposition:
- Shared package `logic_unit_pkg`:
  - Opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11.
  - The opcode width constant (2).
- Sub-module `logic_unit`:
  - Purely combinational: WIDTH-bit a, b, 2-bit op -> WIDTH-bit y.
  - Instantiated once on the muxed winner operands.
- Arbitration (rotate-mask-priority-encode) stays inline.

Test Plan:
1. Reset and idle:
   - Stimulus: assert rst mid-run with res_valid=1.
   - Required: res_valid, res_data, gnt and grant_cnt go to 0 immediately, without waiting for clk.
   - After release with req=0: nothing changes for 10 cycles.
2. Single requester, all opcodes:
   - Stimulus: req=4'b0100, op_a=8'hF0, op_b=8'h3C, opcode 00, 01, 10, 11 in successive transactions, res_ready=1.
   - Required: gnt=4'b0100 each issue; res_data = 8'h30, 8'hFC, 8'hCC, 8'hCF; res_id=2; one-cycle latency.
3. Full contention rotation:
   - Stimulus: req=4'b1111 held, res_ready=1.
   - Required: grant order 0,1,2,3,0,1...; res_valid continuously 1; grant_cnt increases by 1 per cycle.
4. Pointer wrap and skip:
   - Stimulus: after granting requester 3, present req=4'b0110.
   - Required: grant to 1, then 2.
   - Stimulus: then req=4'b0001 only.
   - Required: grant to 0.
5. Backpressure:
   - Stimulus: res_ready=0 for 3 cycles with req=4'b0011 and res_valid=1.
   - Required: gnt=0, res_data and res_id stable.
   - Stimulus: raise res_ready.
   - Required: the next issue happens in the same cycle as the drain, res_valid stays 1.
6. Counter saturation:
   - Stimulus: preload grant_cnt=16'hFFFE via a long run or force, then issue 3 operations.
   - Required: grant_cnt reads 16'hFFFF and holds there.

Source files
------------

// File: rtl/logic_unit_pkg.sv
`default_nettype none
// logic_unit_pkg: opcode encoding shared by the logic unit and its arbiter.
// Rev 1.0
package logic_unit_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_AND  = 2'b00;
  localparam logic [OP_W-1:0] OP_OR   = 2'b01;
  localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
  localparam logic [OP_W-1:0] OP_NAND = 2'b11;

endpackage
`default_nettype wire

// File: rtl/logic_unit.sv
`default_nettype none
// logic_unit: combinational 2-operand bitwise unit (AND, OR, XOR, NAND).
// Rev 1.0
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = a_i & b_i;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      default: y_o = a_i & b_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// logic_unit_arbiter: round-robin sharing of one logic unit among NUM_REQ clients,
// with a single valid/ready result register tagged by the winner index. Rev 1.0
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a,
  input  logic [NUM_REQ*WIDTH-1:0] op_b,
  input  logic [NUM_REQ*OP_W-1:0]  op_sel,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]          res_id,
  input  logic                     res_ready,
  output logic [15:0]              grant_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               res_valid_q, res_valid_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [15:0]        grant_cnt_q, grant_cnt_d;

  logic               can_issue;
  logic               issue;
  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] pool;
  logic [ID_W-1:0]    win_idx;
  logic [WIDTH-1:0]   win_a, win_b, lu_y;
  logic [OP_W-1:0]    win_op;

  assign can_issue = !res_valid_q || res_ready;
  assign issue     = can_issue && (|req) && !rst;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest index.
  always_comb begin
    hi_mask = {NUM_REQ{1'b1}} << ptr_q;
    pool    = ((req & hi_mask) != '0) ? (req & hi_mask) : req;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pool[i]) win_idx = ID_W'(i);
    end
  end

  always_comb begin
    gnt = '0;
    if (issue) gnt[win_idx] = 1'b1;
  end

  assign win_a  = op_a[int'(win_idx)*WIDTH +: WIDTH];
  assign win_b  = op_b[int'(win_idx)*WIDTH +: WIDTH];
  assign win_op = op_sel[int'(win_idx)*OP_W +: OP_W];

  logic_unit #(
    .WIDTH(WIDTH)
  ) u_logic_unit (
    .a_i (win_a),
    .b_i (win_b),
    .op_i(win_op),
    .y_o (lu_y)
  );

  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    grant_cnt_d = grant_cnt_q;
    if (issue) begin
      res_valid_d = 1'b1;
      res_data_d  = lu_y;
      res_id_d    = win_idx;
      ptr_d       = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      if (grant_cnt_q != CNT_MAX) grant_cnt_d = grant_cnt_q + 16'd1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign grant_cnt = grant_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// tb_logic_unit_arbiter: randomized self-checking bench with a behavioural arbiter model.
// Rev 1.0
module tb_logic_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N*2-1:0] op_sel;
  logic           res_ready;
  logic [N-1:0]   gnt;
  logic           res_valid;
  logic [W-1:0]   res_data;
  logic [IW-1:0]  res_id;
  logic [15:0]    grant_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  int           m_cnt;

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .gnt(gnt), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] f_op(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] s);
    case (s)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    int w;
    g = '0;
    w = m_winner();
    if ((!m_valid || res_ready) && w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int w;
    w = m_winner();
    if ((!m_valid || res_ready) && w >= 0) begin
      m_data  = f_op(op_a[w*W +: W], op_b[w*W +: W], op_sel[w*2 +: 2]);
      m_id    = w;
      m_valid = 1;
      m_ptr   = (w + 1) % N;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || grant_cnt !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h id=%0d cnt=%h gnt=%b want all zero",
               res_valid, res_data, res_id, grant_cnt, gnt);
    end
    req = 4'b0001; op_a = $urandom; op_b = $urandom; op_sel = 8'($urandom); res_ready = 1'b1;
    @(posedge clk); model_edge(); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== m_data) begin
      errors++;
      $display("FAIL pre_reset_issue: got v=%b d=%h want v=1 d=%h", res_valid, res_data, m_data);
    end
    req = 4'b1111; res_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || grant_cnt !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b d=%h id=%0d cnt=%h gnt=%b want all zero",
               res_valid, res_data, res_id, grant_cnt, gnt);
    end
    @(posedge clk); #1;
    rst = 1'b0; req = '0; res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); model_edge(); #1;
      checks++;
      if (res_valid !== 1'b0 || res_data !== '0 || grant_cnt !== '0 || gnt !== '0) begin
        errors++;
        $display("FAIL idle cycle %0d: got v=%b d=%h cnt=%h gnt=%b want all zero",
                 c, res_valid, res_data, grant_cnt, gnt);
      end
    end
  endtask

  task automatic test_single_opcodes();
    logic [W-1:0] exp_d [4];
    exp_d = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    for (int k = 0; k < 4; k++) begin
      req = 4'b0100; op_a = $urandom; op_b = $urandom; op_sel = 8'($urandom); res_ready = 1'b1;
      op_a[16 +: 8] = 8'hF0; op_b[16 +: 8] = 8'h3C; op_sel[4 +: 2] = 2'(k);
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
        errors++;
        $display("FAIL single_gnt op=%0d: got %b want 0100", k, gnt);
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_d[k] || res_id !== 2'd2 || res_data !== m_data) begin
        errors++;
        $display("FAIL single_result op=%0d: got v=%b d=%h id=%0d want v=1 d=%h id=2",
                 k, res_valid, res_data, res_id, exp_d[k]);
      end
    end
  endtask

  task automatic test_rotation();
    int start;
    start = m_ptr;
    for (int k = 0; k < 8; k++) begin
      req = 4'b1111; op_a = $urandom; op_b = $urandom; op_sel = 8'($urandom); res_ready = 1'b1;
      #1;
      checks++;
      if (gnt !== (4'b0001 << ((start + k) % N)) || gnt !== m_gnt()) begin
        errors++;
        $display("FAIL rotation_gnt step %0d: got %b want %b", k, gnt, m_gnt());
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (res_valid !== 1'b1 || grant_cnt !== 16'(m_cnt) || res_id !== IW'(m_id) || res_data !== m_data) begin
        errors++;
        $display("FAIL rotation_result step %0d: got v=%b cnt=%0d id=%0d d=%h want v=1 cnt=%0d id=%0d d=%h",
                 k, res_valid, grant_cnt, res_id, res_data, m_cnt, m_id, m_data);
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [N-1:0] reqs [4];
    logic [N-1:0] gnts [4];
    int           ids  [4];
    reqs = '{4'b1000, 4'b0110, 4'b0110, 4'b0001};
    gnts = '{4'b1000, 4'b0010, 4'b0100, 4'b0001};
    ids  = '{3, 1, 2, 0};
    for (int k = 0; k < 4; k++) begin
      req = reqs[k]; op_a = $urandom; op_b = $urandom; op_sel = 8'($urandom); res_ready = 1'b1;
      #1;
      checks++;
      if (gnt !== gnts[k]) begin
        errors++;
        $display("FAIL wrap_gnt step %0d: got %b want %b", k, gnt, gnts[k]);
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (res_id !== IW'(ids[k]) || res_data !== m_data || res_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_result step %0d: got id=%0d d=%h v=%b want id=%0d d=%h v=1",
                 k, res_id, res_data, res_valid, ids[k], m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  held_d;
    logic [IW-1:0] held_id;
    req = 4'b0011; op_a = $urandom; op_b = $urandom; op_sel = 8'($urandom); res_ready = 1'b1;
    @(posedge clk); model_edge(); #1;
    held_d = m_data; held_id = IW'(m_id);
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (gnt !== '0) begin
        errors++;
        $display("FAIL bp_gnt cycle %0d: got %b want 0000", c, gnt);
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== held_d || res_id !== held_id) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                 c, res_valid, res_data, res_id, held_d, held_id);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0001 || gnt !== m_gnt()) begin
      errors++;
      $display("FAIL bp_release_gnt: got %b want 0001", gnt);
    end
    @(posedge clk); model_edge(); #1;
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== m_data) begin
      errors++;
      $display("FAIL bp_release_result: got v=%b id=%0d d=%h want v=1 id=0 d=%h",
               res_valid, res_id, res_data, m_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] last_g;
    req = '0; last_g = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_g[i]) begin
          req[i]            = 1'($urandom_range(0, 1));
          op_a[i*W +: W]    = W'($urandom);
          op_b[i*W +: W]    = W'($urandom);
          op_sel[i*2 +: 2]  = 2'($urandom);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      last_g = m_gnt();
      checks++;
      if (gnt !== last_g) begin
        errors++;
        $display("FAIL random_gnt cycle %0d: got %b want %b", c, gnt, last_g);
      end
      @(posedge clk); model_edge(); #1;
      checks++;
      if (res_valid !== m_valid || res_data !== m_data || res_id !== IW'(m_id) || grant_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random_result cycle %0d: got v=%b d=%h id=%0d cnt=%0d want v=%b d=%h id=%0d cnt=%0d",
                 c, res_valid, res_data, res_id, grant_cnt, m_valid, m_data, m_id, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    int guard;
    guard = 0;
    req = 4'b1111; op_a = $urandom; op_b = $urandom; op_sel = 8'($urandom); res_ready = 1'b1;
    while (m_cnt < 16'hFFFE && guard < 70000) begin
      @(posedge clk); model_edge();
      guard++;
    end
    #1;
    checks++;
    if (grant_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h want fffe", grant_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); model_edge(); #1;
      checks++;
      if (grant_cnt !== 16'hFFFF || m_cnt != 65535) begin
        errors++;
        $display("FAIL sat_hold issue %0d: got %h want ffff", k, grant_cnt);
      end
    end
  endtask

  task automatic test_reset_midrun();
    req = 4'b0001; res_ready = 1'b1;
    @(posedge clk); model_edge(); #1;
    req = 4'b1111;
    #1 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (res_valid !== 1'b0 || grant_cnt !== '0 || res_data !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got v=%b cnt=%h d=%h gnt=%b want all zero",
               res_valid, grant_cnt, res_data, gnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrun_ptr: got %b want 0001", gnt);
    end
    @(posedge clk); model_edge(); #1;
    checks++;
    if (grant_cnt !== 16'd1 || res_id !== 2'd0 || res_valid !== 1'b1 || res_data !== m_data) begin
      errors++;
      $display("FAIL midrun_first: got cnt=%0d id=%0d v=%b d=%h want cnt=1 id=0 v=1 d=%h",
               grant_cnt, res_id, res_valid, res_data, m_data);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; op_a = '0; op_b = '0; op_sel = '0; res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single_opcodes();
    test_rotation();
    test_wrap_skip();
    test_backpressure();
    test_random();
    test_saturation();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
